irq_controller: RTL and testbench

Interrupt controller for the MINX system block: collects 16 peripheral interrupt sources (PRC copy-complete/render-done, timers, keypad, …), holds them in software-visible flag registers, and presents the highest-priority enabled request to the S1C88 core. It is a bus slave on the 0x2020–0x2024 register window, and its read data is OR-combined into the system register read path. It sits directly upstream of the CPU's interrupt request input.

---
 rtl/minx_irq_pkg.sv | 47 ++++
 rtl/irq_controller_if.sv | 18 +
 rtl/irq_controller_arbiter.sv | 33 +++
 rtl/irq_controller.sv | 110 +++++++++++
 tb/tb_irq_controller.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/minx_irq_pkg.sv
// Shared definitions for the MINX interrupt controller: register map,
// source numbering, priority type and register decode helper.
package minx_irq_pkg;

  localparam int IRQ_NUM_SRC     = 16;
  localparam int IRQ_NUM_GRP     = 4;
  localparam int IRQ_SRC_PER_GRP = 4;

  localparam logic [23:0] IRQ_PRI_ADDR     = 24'h2020;
  localparam logic [23:0] IRQ_EN_LO_ADDR   = 24'h2021;
  localparam logic [23:0] IRQ_EN_HI_ADDR   = 24'h2022;
  localparam logic [23:0] IRQ_FLAG_LO_ADDR = 24'h2023;
  localparam logic [23:0] IRQ_FLAG_HI_ADDR = 24'h2024;

  localparam int IRQ_SRC_PRC_COPY   = 0;
  localparam int IRQ_SRC_PRC_RENDER = 1;
  localparam int IRQ_SRC_TIMER256   = 4;

  localparam logic [4:0] IRQ_VECTOR_BASE = 5'd3;

  typedef logic [1:0] irq_pri_t;

  typedef enum logic [2:0] {
    REG_PRI,
    REG_EN_LO,
    REG_EN_HI,
    REG_FLAG_LO,
    REG_FLAG_HI,
    REG_NONE
  } irq_reg_e;

  // Full 24-bit decode relative to the block base address.
  function automatic irq_reg_e irq_decode(input logic [23:0] addr,
                                          input logic [23:0] base);
    logic [23:0] off;
    off = addr - base;
    case (off)
      24'd0:   return REG_PRI;
      24'd1:   return REG_EN_LO;
      24'd2:   return REG_EN_HI;
      24'd3:   return REG_FLAG_LO;
      24'd4:   return REG_FLAG_HI;
      default: return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// System register bus as seen by the interrupt controller.
interface irq_controller_if;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;

  modport master (
    output bus_write, bus_read, bus_address_in, bus_data_in,
    input  bus_data_out
  );

  modport slave (
    input  bus_write, bus_read, bus_address_in, bus_data_in,
    output bus_data_out
  );
endinterface

// File: rtl/irq_controller_arbiter.sv
// Combinational priority arbiter: highest group priority wins, lowest
// source index breaks ties; priority-0 groups never win.
module irq_arbiter
  import minx_irq_pkg::*;
#(
  parameter int NUM_SRC = IRQ_NUM_SRC,
  localparam int NUM_GRP = NUM_SRC / IRQ_SRC_PER_GRP,
  localparam int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]          cand_i,
  input  irq_pri_t [NUM_GRP-1:0]      grp_pri_i,
  output irq_pri_t                    level_o,
  output logic [IDX_W-1:0]            idx_o
);

  irq_pri_t         best_lvl;
  logic [IDX_W-1:0] best_idx;

  always_comb begin
    best_lvl = '0;
    best_idx = '0;
    // Ascending scan with strict compare keeps the lowest index on ties.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cand_i[i] && (grp_pri_i[i / IRQ_SRC_PER_GRP] > best_lvl)) begin
        best_lvl = grp_pri_i[i / IRQ_SRC_PER_GRP];
        best_idx = i[IDX_W-1:0];
      end
    end
    level_o = best_lvl;
    idx_o   = best_idx;
  end

endmodule

// File: rtl/irq_controller.sv
// MINX interrupt controller: edge-detected source flags, enables, group
// priorities and a registered request to the core with iack hold.
module irq_controller
  import minx_irq_pkg::*;
#(
  parameter int          NUM_SRC   = IRQ_NUM_SRC,
  parameter logic [23:0] BASE_ADDR = IRQ_PRI_ADDR
) (
  input  logic               clk,
  input  logic               reset,
  irq_controller_if.slave    bus,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               iack,
  output irq_pri_t           irq_level,
  output logic [4:0]         irq_vector
);

  localparam int NUM_GRP = NUM_SRC / IRQ_SRC_PER_GRP;
  localparam int IDX_W   = $clog2(NUM_SRC);

  logic [7:0]         pri_q, pri_d;
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [NUM_SRC-1:0] flag_q, flag_d;
  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
  irq_pri_t           level_q, level_d;
  logic [4:0]         vector_q, vector_d;

  logic [NUM_SRC-1:0]     clr;
  logic [NUM_SRC-1:0]     rise;
  logic [NUM_SRC-1:0]     cand;
  irq_pri_t [NUM_GRP-1:0] grp_pri;
  irq_pri_t               arb_level;
  logic [IDX_W-1:0]       arb_idx;
  irq_reg_e               wr_reg, rd_reg;

  assign grp_pri = pri_q;
  assign cand    = flag_q & en_q;

  irq_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .cand_i    (cand),
    .grp_pri_i (grp_pri),
    .level_o   (arb_level),
    .idx_o     (arb_idx)
  );

  always_comb begin
    wr_reg = bus.bus_write ? irq_decode(bus.bus_address_in, BASE_ADDR) : REG_NONE;
    pri_d  = pri_q;
    en_d   = en_q;
    clr    = '0;
    case (wr_reg)
      REG_PRI:     pri_d       = bus.bus_data_in;
      REG_EN_LO:   en_d[7:0]   = bus.bus_data_in;
      REG_EN_HI:   en_d[15:8]  = bus.bus_data_in;
      REG_FLAG_LO: clr[7:0]    = bus.bus_data_in;
      REG_FLAG_HI: clr[15:8]   = bus.bus_data_in;
      default: ;
    endcase
    rise       = irq_src & ~src_prev_q;
    // A new edge outranks a same-cycle write-1-clear.
    flag_d     = (flag_q & ~clr) | rise;
    src_prev_d = irq_src;
  end

  always_comb begin
    level_d  = level_q;
    vector_d = vector_q;
    if (!iack) begin
      level_d  = arb_level;
      vector_d = (arb_level != '0) ? ({1'b0, arb_idx} + IRQ_VECTOR_BASE) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pri_q      <= '0;
      en_q       <= '0;
      flag_q     <= '0;
      src_prev_q <= '0;
      level_q    <= '0;
      vector_q   <= '0;
    end else begin
      pri_q      <= pri_d;
      en_q       <= en_d;
      flag_q     <= flag_d;
      src_prev_q <= src_prev_d;
      level_q    <= level_d;
      vector_q   <= vector_d;
    end
  end

  always_comb begin
    rd_reg           = irq_decode(bus.bus_address_in, BASE_ADDR);
    bus.bus_data_out = '0;
    if (bus.bus_read) begin
      case (rd_reg)
        REG_PRI:     bus.bus_data_out = pri_q;
        REG_EN_LO:   bus.bus_data_out = en_q[7:0];
        REG_EN_HI:   bus.bus_data_out = en_q[15:8];
        REG_FLAG_LO: bus.bus_data_out = flag_q[7:0];
        REG_FLAG_HI: bus.bus_data_out = flag_q[15:8];
        default: ;
      endcase
    end
  end

  assign irq_level  = level_q;
  assign irq_vector = vector_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: expectations are queued as stimulus
// is applied and popped against bus reads and the registered request.
module tb_irq_controller;
  import minx_irq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] irq_src;
  logic        iack;
  irq_pri_t    irq_level;
  logic [4:0]  irq_vector;

  irq_controller_if bus_if();

  irq_controller #(.NUM_SRC(16), .BASE_ADDR(24'h2020)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if.slave),
    .irq_src    (irq_src),
    .iack       (iack),
    .irq_level  (irq_level),
    .irq_vector (irq_vector)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk = 0;
  int  n_err = 0;
  logic [7:0] rd_d;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [15:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [15:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 16'(sb_q.size()), 16'd1);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, act, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [23:0] a, input logic [7:0] d);
    bus_if.bus_write      = 1'b1;
    bus_if.bus_address_in = a;
    bus_if.bus_data_in    = d;
    tick();
    bus_if.bus_write      = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [23:0] a, input logic [7:0] exp);
    sb_push(tag, {8'd0, exp});
    bus_if.bus_read       = 1'b1;
    bus_if.bus_address_in = a;
    #1;
    rd_d = bus_if.bus_data_out;
    bus_if.bus_read       = 1'b0;
    sb_pop({8'd0, rd_d});
  endtask

  task automatic irq_chk(input string tag, input irq_pri_t lvl, input logic [4:0] vec);
    sb_push(tag, {9'd0, lvl, vec});
    sb_pop({9'd0, irq_level, irq_vector});
  endtask

  initial begin
    reset                 = 1'b1;
    irq_src               = '0;
    iack                  = 1'b0;
    bus_if.bus_write      = 1'b0;
    bus_if.bus_read       = 1'b0;
    bus_if.bus_address_in = '0;
    bus_if.bus_data_in    = '0;
    tick();
    tick();
    reset = 1'b0;

    irq_chk("rst_irq", 2'd0, 5'd0);
    for (int a = 0; a < 5; a++) rd_chk("rst_reg", IRQ_PRI_ADDR + 24'(a), 8'h00);

    // Basic request from source 0
    wr(IRQ_PRI_ADDR, 8'h03);
    wr(IRQ_EN_LO_ADDR, 8'h01);
    rd_chk("pri_rd", IRQ_PRI_ADDR, 8'h03);
    rd_chk("en_lo_rd", IRQ_EN_LO_ADDR, 8'h01);
    irq_src[IRQ_SRC_PRC_COPY] = 1'b1;
    tick();
    irq_src[IRQ_SRC_PRC_COPY] = 1'b0;
    rd_chk("flag0_set", IRQ_FLAG_LO_ADDR, 8'h01);
    irq_chk("lat_1clk", 2'd0, 5'd0);
    tick();
    irq_chk("req_src0", 2'd3, 5'd3);

    wr(IRQ_FLAG_LO_ADDR, 8'h01);
    irq_chk("clr_lat", 2'd3, 5'd3);
    tick();
    irq_chk("clr_drop", 2'd0, 5'd0);

    // Masked source, then enabled late
    wr(IRQ_EN_LO_ADDR, 8'h00);
    irq_src[IRQ_SRC_PRC_RENDER] = 1'b1;
    tick();
    irq_src[IRQ_SRC_PRC_RENDER] = 1'b0;
    rd_chk("flag1_masked", IRQ_FLAG_LO_ADDR, 8'h02);
    tick();
    tick();
    irq_chk("masked_idle", 2'd0, 5'd0);
    wr(IRQ_EN_LO_ADDR, 8'h02);
    irq_chk("en_lat", 2'd0, 5'd0);
    tick();
    irq_chk("en_req", 2'd3, 5'd4);

    // Cross-group arbitration
    wr(IRQ_FLAG_LO_ADDR, 8'h02);
    wr(IRQ_PRI_ADDR, 8'h0D);
    wr(IRQ_EN_LO_ADDR, 8'hFF);
    wr(IRQ_EN_HI_ADDR, 8'hFF);
    irq_src = 16'h0021;
    tick();
    irq_src = '0;
    tick();
    irq_chk("arb_grp1", 2'd3, 5'd8);

    // iack holds the request while flags keep changing
    iack = 1'b1;
    wr(IRQ_FLAG_LO_ADDR, 8'h20);
    tick();
    tick();
    irq_chk("iack_hold", 2'd3, 5'd8);
    rd_chk("iack_flag_clr", IRQ_FLAG_LO_ADDR, 8'h01);
    iack = 1'b0;
    tick();
    irq_chk("iack_rel", 2'd1, 5'd3);

    // Equal priorities across groups, then a priority-0 group
    irq_src[5] = 1'b1;
    tick();
    irq_src = '0;
    wr(IRQ_PRI_ADDR, 8'h0F);
    tick();
    irq_chk("tie_low_idx", 2'd3, 5'd3);
    wr(IRQ_PRI_ADDR, 8'h0C);
    tick();
    irq_chk("pri0_excl", 2'd3, 5'd8);

    // Highest source index in the top group
    wr(IRQ_FLAG_LO_ADDR, 8'hFF);
    wr(IRQ_PRI_ADDR, 8'h40);
    irq_src[15] = 1'b1;
    tick();
    irq_src = '0;
    rd_chk("flag15", IRQ_FLAG_HI_ADDR, 8'h80);
    rd_chk("flag_lo_clr", IRQ_FLAG_LO_ADDR, 8'h00);
    tick();
    irq_chk("req_src15", 2'd1, 5'd18);

    // Set and write-1-clear on the same edge
    irq_src[0] = 1'b1;
    tick();
    irq_src[0] = 1'b0;
    tick();
    irq_src[0] = 1'b1;
    wr(IRQ_FLAG_LO_ADDR, 8'h01);
    irq_src[0] = 1'b0;
    rd_chk("set_wins", IRQ_FLAG_LO_ADDR, 8'h01);

    // Outside the register window
    wr(24'h002025, 8'hFF);
    wr(24'h012020, 8'hFF);
    rd_chk("oow_2025", 24'h002025, 8'h00);
    rd_chk("oow_201f", 24'h00201F, 8'h00);
    rd_chk("oow_alias", 24'h012020, 8'h00);
    rd_chk("pri_kept", IRQ_PRI_ADDR, 8'h40);
    sb_push("no_rd_strobe", 16'h0000);
    bus_if.bus_address_in = IRQ_PRI_ADDR;
    #1;
    sb_pop({8'd0, bus_if.bus_data_out});

    // Reset in the middle of an active request
    irq_src[2] = 1'b1;
    tick();
    tick();
    rd_chk("pre_rst_flag", IRQ_FLAG_LO_ADDR, 8'h05);
    irq_chk("pre_rst_irq", 2'd1, 5'd18);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    irq_chk("post_rst_irq", 2'd0, 5'd0);
    for (int a = 0; a < 5; a++) rd_chk("post_rst_reg", IRQ_PRI_ADDR + 24'(a), 8'h00);
    tick();
    rd_chk("held_src_sets", IRQ_FLAG_LO_ADDR, 8'h04);
    irq_chk("post_rst_idle", 2'd0, 5'd0);
    irq_src = '0;

    chk("sb_drain", 16'(sb_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
